id_ex_pipe: RTL

//  ID/EX pipeline register and load-use hazard detector, directly downstream of control decode.

---
 rtl/control_types_pkg.sv | 33 +++
 rtl/load_use_detect.sv | 19 +
 rtl/id_ex_pipe.sv | 93 +++++++++
 3 files changed

// File: rtl/control_types_pkg.sv
// control_types_pkg: decoded control bundle types shared by decode and the ID/EX register
package control_types_pkg;
  localparam int XLEN_DEF = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int PERF_CNT_W_DEF = 32;
  typedef enum logic [2:0] {BR_NOP, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} comp_op_t;
  typedef enum logic [1:0] {WRSRC_ALURES, WRSRC_MEMRES, WRSRC_PCPLUS4, WRSRC_IMM} wrsrc_t;
  typedef enum logic [1:0] {SRC1_REG1, SRC1_PC, SRC1_ZERO} src1_t;
  typedef enum logic {SRC2_REG2, SRC2_IMM} src2_t;
  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_t;
  typedef enum logic [2:0] {MEM_NOP, MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU} mem_op_t;
  typedef struct packed {
    logic     reg_do_write;
    logic     mem_do_write;
    logic     mem_do_read;
    logic     do_branch;
    logic     do_jump;
    comp_op_t comp_op;
    wrsrc_t   wrsrc;
    src1_t    src1;
    src2_t    src2;
    alu_op_t  alu_op;
    mem_op_t  mem_op;
  } id_ex_ctrl_t;
  localparam id_ex_ctrl_t CTRL_BUBBLE = '{
    reg_do_write: 1'b0, mem_do_write: 1'b0, mem_do_read: 1'b0,
    do_branch: 1'b0, do_jump: 1'b0, comp_op: BR_NOP, wrsrc: WRSRC_ALURES,
    src1: SRC1_REG1, src2: SRC2_REG2, alu_op: ALU_NOP, mem_op: MEM_NOP
  };
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the destination of a load sitting in EX
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  ex_valid,
  input  logic                  ex_mem_do_read,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  load_use
);
  logic rs1_hit, rs2_hit;
  assign rs1_hit = id_uses_rs1 && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit = id_uses_rs2 && (id_rs2_addr == ex_rd_addr);
  assign load_use = id_valid && ex_valid && ex_mem_do_read && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use bubble insertion, flush and EX back-pressure.
// Optional perf counters enabled by defining ID_EX_PERF_EN.
module id_ex_pipe
  import control_types_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int PERF_CNT_W = PERF_CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  id_ex_ctrl_t           id_ctrl,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic                  flush_i,
  input  logic                  ex_stall_i,
  output logic                  ex_valid,
  output id_ex_ctrl_t           ex_ctrl,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_rs1_data,
  output logic [XLEN-1:0]       ex_rs2_data,
  output logic [XLEN-1:0]       ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1_addr,
  output logic [REG_ADDR_W-1:0] ex_rs2_addr,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  id_stall_o,
  output logic [PERF_CNT_W-1:0] perf_bubble_cnt,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt
);
  logic load_use, bubble;
  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_detect (
    .id_valid       (id_valid),
    .id_uses_rs1    (id_uses_rs1),
    .id_uses_rs2    (id_uses_rs2),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .ex_valid       (ex_valid),
    .ex_mem_do_read (ex_ctrl.mem_do_read),
    .ex_rd_addr     (ex_rd_addr),
    .load_use       (load_use)
  );
  // Flush beats a hold; a hold beats a load-use bubble so the hazard is rechecked next cycle.
  assign bubble = flush_i || (!ex_stall_i && load_use);
  assign id_stall_o = !rst && !flush_i && (ex_stall_i || load_use);
  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1_addr <= '0;
      ex_rs2_addr <= '0;
      ex_rd_addr  <= '0;
    end else if (!ex_stall_i) begin
      ex_valid    <= id_valid;
      ex_ctrl     <= id_valid ? id_ctrl : CTRL_BUBBLE;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1_addr <= id_rs1_addr;
      ex_rs2_addr <= id_rs2_addr;
      ex_rd_addr  <= id_rd_addr;
    end
  end
`ifdef ID_EX_PERF_EN
  logic [PERF_CNT_W-1:0] bubble_cnt, flush_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (!flush_i && !ex_stall_i && load_use && bubble_cnt != '1) bubble_cnt <= bubble_cnt + PERF_CNT_W'(1);
      if (flush_i && flush_cnt != '1) flush_cnt <= flush_cnt + PERF_CNT_W'(1);
    end
  end
  assign perf_bubble_cnt = bubble_cnt;
  assign perf_flush_cnt  = flush_cnt;
`else
  assign perf_bubble_cnt = '0;
  assign perf_flush_cnt  = '0;
`endif
endmodule
